jtdsp16_rom_loader: RTL and testbench

//  Upstream feeder of the DSP16 internal program ROM. Accepts a little-endian byte stream
//  (valid/ready) from the download/SDRAM side and converts it into the ROM programming

---
 rtl/jtdsp16_pkg.sv | 14 +
 rtl/jtdsp16_rom_loader.sv | 140 ++++++++++++++
 tb/tb_jtdsp16_rom_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the DSP16 ROM loader: state encoding and ROM address width.
package jtdsp16_pkg;

    localparam int unsigned ROM_AW = 13;
    localparam int unsigned CNT_W  = ROM_AW + 1;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_DONE = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/jtdsp16_rom_loader.sv
// Byte-stream to DSP16 program-ROM writer; holds the core in reset until the image lands.
// Optional word checksum built only when JTDSP16_LOADER_CKSUM_EN is defined.
module jtdsp16_rom_loader
    import jtdsp16_pkg::*;
#(
    parameter int unsigned ROM_BYTES   = 8192,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reload_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [ROM_AW-1:0] prog_addr_o,
    output logic [7:0]        prog_data_o,
    output logic              prog_we_o,
    output logic              loading_o,
    output logic              done_o,
    output logic              cpu_rst_n_o,
    output logic [15:0]       cksum_o
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic [ROM_AW-1:0]   prog_addr_q;
    logic [7:0]          prog_data_q;
    logic                prog_we_q;
    logic                accept;

    assign byte_ready_o = (state_q == ST_LOAD) && !reload_i;
    assign accept       = byte_valid_i && byte_ready_o;

    // Next-state: reload overrides everything and restarts from address 0
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hold_d      = hold_q;
        cpu_rst_n_d = cpu_rst_n_q;
        if (reload_i) begin
            state_d     = ST_LOAD;
            count_d     = '0;
            hold_d      = '0;
            cpu_rst_n_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        count_d = count_q + CNT_W'(1);
                        if (count_q == CNT_W'(ROM_BYTES - 1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    hold_d = hold_q + HOLD_W'(1);
                    if (hold_d == HOLD_W'(HOLD_CYCLES)) begin
                        state_d     = ST_RUN;
                        cpu_rst_n_d = 1'b1;
                    end
                end
                ST_RUN:  ;
                default: state_d = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            count_q     <= '0;
            hold_q      <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    // Write port lags acceptance by one cycle; address/data hold between strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
        end else begin
            prog_we_q <= accept;
            if (accept) begin
                prog_addr_q <= count_q[ROM_AW-1:0];
                prog_data_q <= byte_data_i;
            end
        end
    end

`ifdef JTDSP16_LOADER_CKSUM_EN
    logic [15:0] cksum_q, cksum_d;
    logic [7:0]  lsb_q, lsb_d;

    // Summed at acceptance so the value is final in the cycle done rises
    always_comb begin
        cksum_d = cksum_q;
        lsb_d   = lsb_q;
        if (reload_i) begin
            cksum_d = '0;
        end else if (accept) begin
            if (count_q[0]) begin
                cksum_d = cksum_q + {byte_data_i, lsb_q};
            end else begin
                lsb_d = byte_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cksum_q <= '0;
            lsb_q   <= '0;
        end else begin
            cksum_q <= cksum_d;
            lsb_q   <= lsb_d;
        end
    end

    assign cksum_o = cksum_q;
`else
    assign cksum_o = 16'd0;
`endif

    assign prog_addr_o = prog_addr_q;
    assign prog_data_o = prog_data_q;
    assign prog_we_o   = prog_we_q;
    assign loading_o   = (state_q == ST_LOAD);
    assign done_o      = (state_q == ST_DONE) || (state_q == ST_RUN);
    assign cpu_rst_n_o = cpu_rst_n_q;

endmodule

// File: tb/tb_jtdsp16_rom_loader.sv
// Self-checking bench for jtdsp16_rom_loader: full image, gaps, reload, reset, small image, checksum.
module tb_jtdsp16_rom_loader;
    import jtdsp16_pkg::*;

    localparam int unsigned BIG_BYTES = 8192;
    localparam int unsigned BIG_HOLD  = 16;
    localparam int unsigned S_BYTES   = 16;
    localparam int unsigned S_HOLD    = 4;
    localparam int unsigned C_BYTES   = 4;
    localparam int unsigned C_HOLD    = 2;

    typedef struct packed {
        logic [ROM_AW-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Large image instance
    logic              b_rst_n, b_reload, b_bv, b_br, b_pwe, b_loading, b_done, b_cpu;
    logic [7:0]        b_bd, b_pd;
    logic [ROM_AW-1:0] b_pa;
    logic [15:0]       b_cks;

    jtdsp16_rom_loader #(.ROM_BYTES(BIG_BYTES), .HOLD_CYCLES(BIG_HOLD)) u_big (
        .clk(clk), .rst_n(b_rst_n), .reload_i(b_reload), .byte_data_i(b_bd),
        .byte_valid_i(b_bv), .byte_ready_o(b_br), .prog_addr_o(b_pa), .prog_data_o(b_pd),
        .prog_we_o(b_pwe), .loading_o(b_loading), .done_o(b_done), .cpu_rst_n_o(b_cpu),
        .cksum_o(b_cks)
    );

    // Small image and checksum instances share one reset
    logic              sc_rst_n;
    logic              s_reload, s_bv, s_br, s_pwe, s_loading, s_done, s_cpu;
    logic [7:0]        s_bd, s_pd;
    logic [ROM_AW-1:0] s_pa;
    logic [15:0]       s_cks;
    logic              c_reload, c_bv, c_br, c_pwe, c_loading, c_done, c_cpu;
    logic [7:0]        c_bd, c_pd;
    logic [ROM_AW-1:0] c_pa;
    logic [15:0]       c_cks;

    jtdsp16_rom_loader #(.ROM_BYTES(S_BYTES), .HOLD_CYCLES(S_HOLD)) u_small (
        .clk(clk), .rst_n(sc_rst_n), .reload_i(s_reload), .byte_data_i(s_bd),
        .byte_valid_i(s_bv), .byte_ready_o(s_br), .prog_addr_o(s_pa), .prog_data_o(s_pd),
        .prog_we_o(s_pwe), .loading_o(s_loading), .done_o(s_done), .cpu_rst_n_o(s_cpu),
        .cksum_o(s_cks)
    );

    jtdsp16_rom_loader #(.ROM_BYTES(C_BYTES), .HOLD_CYCLES(C_HOLD)) u_cks (
        .clk(clk), .rst_n(sc_rst_n), .reload_i(c_reload), .byte_data_i(c_bd),
        .byte_valid_i(c_bv), .byte_ready_o(c_br), .prog_addr_o(c_pa), .prog_data_o(c_pd),
        .prog_we_o(c_pwe), .loading_o(c_loading), .done_o(c_done), .cpu_rst_n_o(c_cpu),
        .cksum_o(c_cks)
    );

    // Scoreboard for the large instance: push on modelled acceptance, pop on prog_we
    wr_t b_q[$];
    wr_t b_e;
    int  m_cnt  = 0;
    bit  m_full = 1'b0;
    bit  m_pend = 1'b0;
    bit  mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("b_we", 32'(b_pwe), 32'(m_pend));
            if (b_pwe === 1'b1) begin
                if (b_q.size() == 0) begin
                    chk("b_sb_underflow", 32'(b_q.size()), 32'd1);
                end else begin
                    b_e = b_q.pop_front();
                    chk("b_addr", 32'(b_pa), 32'(b_e.addr));
                    chk("b_data", 32'(b_pd), 32'(b_e.data));
                end
            end
            chk("b_ready", 32'(b_br), 32'(!m_full && !b_reload));
            m_pend = 1'b0;
            if (!b_rst_n) begin
                m_cnt  = 0;
                m_full = 1'b0;
                b_q.delete();
            end else if (b_reload) begin
                m_cnt  = 0;
                m_full = 1'b0;
            end else if (b_bv && !m_full) begin
                b_q.push_back('{addr: ROM_AW'(m_cnt), data: b_bd});
                m_cnt++;
                m_pend = 1'b1;
                if (m_cnt == int'(BIG_BYTES)) m_full = 1'b1;
            end
        end
    end

    task automatic stream(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            b_bv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            b_bd = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    wr_t         s_q[$];
    wr_t         s_e;
    logic [15:0] s_cks_exp;
    logic [15:0] c_cks_exp;
    logic [7:0]  c_bytes [4];

    initial begin
        b_rst_n = 1'b0; b_reload = 1'b0; b_bv = 1'b0; b_bd = '0;
        sc_rst_n = 1'b0;
        s_reload = 1'b0; s_bv = 1'b0; s_bd = '0;
        c_reload = 1'b0; c_bv = 1'b0; c_bd = '0;
        c_bytes[0] = 8'h34; c_bytes[1] = 8'h12; c_bytes[2] = 8'h78; c_bytes[3] = 8'h56;
        s_cks_exp = '0;
        c_cks_exp = '0;
`ifdef JTDSP16_LOADER_CKSUM_EN
        for (int k = 0; k < int'(S_BYTES); k += 2) s_cks_exp += {8'(k + 1), 8'(k)};
        c_cks_exp = 16'h1234 + 16'h5678;
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_loading", 32'(b_loading), 32'd1);
        chk("rst_done",    32'(b_done),    32'd0);
        chk("rst_cpu",     32'(b_cpu),     32'd0);
        chk("rst_we",      32'(b_pwe),     32'd0);
        chk("rst_addr",    32'(b_pa),      32'd0);
        chk("rst_data",    32'(b_pd),      32'd0);
        chk("rst_cksum",   32'(b_cks),     32'd0);
        chk("rst_ready",   32'(b_br),      32'd1);
        @(posedge clk); #1;
        b_rst_n = 1'b1; sc_rst_n = 1'b1; mon_en = 1'b1;

        // Reload after 100 bytes: restart at address 0, core stays in reset
        stream(100, 1'b0);
        b_reload = 1'b1;
        @(negedge clk);
        chk("reload_done", 32'(b_done), 32'd0);
        chk("reload_cpu",  32'(b_cpu),  32'd0);
        @(posedge clk); #1;
        b_reload = 1'b0;
        @(negedge clk);
        chk("post_reload_loading", 32'(b_loading), 32'd1);
        chk("post_reload_cpu",     32'(b_cpu),     32'd0);
        @(posedge clk); #1;

        // Synchronous reset mid-load with a byte offered in the reset cycle
        stream(60, 1'b0);
        b_rst_n = 1'b0;
        @(posedge clk); #1;
        b_rst_n = 1'b1; b_bv = 1'b0;
        @(negedge clk);
        chk("midrst_addr",    32'(b_pa),      32'd0);
        chk("midrst_data",    32'(b_pd),      32'd0);
        chk("midrst_loading", 32'(b_loading), 32'd1);
        chk("midrst_done",    32'(b_done),    32'd0);
        chk("midrst_cpu",     32'(b_cpu),     32'd0);
        @(posedge clk); #1;

        stream(400, 1'b1);

        // Full image back to back, then surplus valid bytes
        b_rst_n = 1'b0; b_bv = 1'b0;
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        stream(int'(BIG_BYTES), 1'b0);
        @(negedge clk);
        chk("full_done",    32'(b_done),    32'd1);
        chk("full_loading", 32'(b_loading), 32'd0);
        chk("full_cpu0",    32'(b_cpu),     32'd0);
        for (int k = 1; k <= int'(BIG_HOLD); k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("hold_cpu_%0d", k), 32'(b_cpu), 32'(k == int'(BIG_HOLD)));
        end
        chk("run_done", 32'(b_done), 32'd1);
        #1;
        chk("b_sb_empty", 32'(b_q.size()), 32'd0);
        @(posedge clk); #1;
        b_bv = 1'b0;

        // 16-byte image with 4 surplus bytes
        s_bv = 1'b1;
        for (int i = 0; i < int'(S_BYTES) + 4; i++) begin
            s_bd = 8'(i);
            @(negedge clk);
            if (i > 0) begin
                chk("s_we", 32'(s_pwe), 32'((i - 1) < int'(S_BYTES)));
                if (s_pwe === 1'b1 && s_q.size() > 0) begin
                    s_e = s_q.pop_front();
                    chk("s_addr", 32'(s_pa), 32'(s_e.addr));
                    chk("s_data", 32'(s_pd), 32'(s_e.data));
                end
            end
            chk("s_ready", 32'(s_br), 32'(i < int'(S_BYTES)));
            if (i < int'(S_BYTES)) s_q.push_back('{addr: ROM_AW'(i), data: 8'(i)});
            @(posedge clk); #1;
        end
        s_bv = 1'b0;
        @(negedge clk);
        chk("s_final_we",   32'(s_pwe),     32'd0);
        chk("s_final_addr", 32'(s_pa),      32'd15);
        chk("s_final_data", 32'(s_pd),      32'h0F);
        chk("s_done",       32'(s_done),    32'd1);
        chk("s_loading",    32'(s_loading), 32'd0);
        chk("s_cpu",        32'(s_cpu),     32'd1);
        chk("s_cksum",      32'(s_cks),     32'(s_cks_exp));
        chk("s_sb_empty",   32'(s_q.size()), 32'd0);
        @(posedge clk); #1;

        // Checksum image 34 12 78 56
        c_bv = 1'b1;
        for (int i = 0; i < int'(C_BYTES); i++) begin
            c_bd = c_bytes[i];
            @(posedge clk); #1;
        end
        c_bv = 1'b0;
        @(negedge clk);
        chk("c_done",  32'(c_done), 32'd1);
        chk("c_cksum", 32'(c_cks),  32'(c_cks_exp));
        chk("c_we",    32'(c_pwe),  32'd1);
        chk("c_addr",  32'(c_pa),   32'd3);
        chk("c_data",  32'(c_pd),   32'h56);
        chk("c_ready", 32'(c_br),   32'd0);
        chk("c_cpu0",  32'(c_cpu),  32'd0);
        @(posedge clk); @(negedge clk);
        chk("c_cpu1",  32'(c_cpu),  32'd0);
        @(posedge clk); @(negedge clk);
        chk("c_cpu2",  32'(c_cpu),  32'd1);
        @(posedge clk); #1;
        c_reload = 1'b1;
        @(posedge clk); #1;
        c_reload = 1'b0;
        @(negedge clk);
        chk("c_reload_cksum",   32'(c_cks),     32'd0);
        chk("c_reload_done",    32'(c_done),    32'd0);
        chk("c_reload_loading", 32'(c_loading), 32'd1);
        chk("c_reload_cpu",     32'(c_cpu),     32'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
